dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (data_mem) between the processor core load/store port (m0)
//  and a host/loader port (m1), which preloads operands and reads results. Sits between
//  processor_top's dmem interface and data_mem. Pipelined: one access accepted per cycle,
//  response one cycle later. Selectable round-robin or core-priority with starvation guard,
//  plus host burst lock.
// PARAMETERS
//  ADDR_W        10   word-address width (dmem depth = 2**ADDR_W words)
//  DATA_W        32   data width; strobe width = DATA_W/8
//  PRIO_MODE     0    0 = round-robin; 1 = core priority + starvation guard
//  STARVE_LIMIT  8    PRIO_MODE=1: consecutive host-waiting cycles before host is forced
//  BURST_MAX     4    max consecutive host grants while m1_lock is held
// PORTS
//  clk            in   1         system clock, all state on rising edge
//  rst            in   1         reset, asynchronous, active-high
//  m0_req_valid   in   1         core request valid
//  m0_req_ready   out  1         core request accepted this cycle (valid&&ready)
//  m0_req_we      in   1         1 = write, 0 = read
//  m0_req_addr    in   ADDR_W    core word address
//  m0_req_wdata   in   DATA_W    core write data
//  m0_req_wstrb   in   DATA_W/8  core byte strobes
//  m0_rsp_valid   out  1         one-cycle pulse: read data valid / write ack
//  m0_rsp_rdata   out  DATA_W    read data (0 for write ack)
//  m1_*           --   --        host port, same set and widths as m0_*
//  m1_lock        in   1         host requests back-to-back burst ownership
//  mem_en         out  1         memory access strobe
//  mem_we         out  1         memory write enable
//  mem_wstrb      out  DATA_W/8  memory byte strobes
//  mem_addr       out  ADDR_W    memory word address
//  mem_wdata      out  DATA_W    memory write data
//  mem_rdata      in   DATA_W    memory read data, valid 1 cycle after mem_en
// BEHAVIOUR
//  - Reset: all registered outputs 0; rr_ptr=core; wait_cnt=0; burst_cnt=0; state=ARB; in-flight
//    response dropped (a write already issued to memory completes; no rsp pulse).
//  - Handshake: requester holds valid and payload stable until ready. ready is combinational from
//    valid + arbiter state; only the winner sees ready=1. mem_* are combinational copies of the
//    winner's payload; mem_en = any grant. Owner tag and we registered at accept.
//  - Latency: accept in cycle N -> rsp_valid to owner in cycle N+1, rdata = mem_rdata (write: 0).
//    Both ports can accept on consecutive cycles, full throughput, no bubbles.
//  - ARB, PRIO_MODE=0: one requester valid -> it wins. Both valid -> rr_ptr side wins; rr_ptr flips
//    to the other side after each contested grant.
//  - ARB, PRIO_MODE=1: core wins ties. wait_cnt++ each cycle host valid and not granted; reset on
//    host grant. When wait_cnt==STARVE_LIMIT, host wins the next contested cycle.
//  - Burst FSM: ARB -> HBURST when host is granted with m1_lock=1 (burst_cnt=1).
//    In HBURST, host always wins when valid. Each host grant increments burst_cnt.
//    HBURST -> RELEASE when m1_lock=0, host not valid, or burst_cnt==BURST_MAX.
//    In RELEASE, host ready=0 for one cycle; core wins if valid; then -> ARB.
//  - Simultaneous accept and response for different owners in the same cycle is legal.
//  - Widths: counters sized $clog2(limit+1); saturate, never wrap.
// STRUCTURE
//  - dmem_arb_defs.vh (shared define/package file): OWN_CORE=0, OWN_HOST=1;
//    ST_ARB, ST_HBURST, ST_RELEASE; PRIO_RR=0, PRIO_CORE=1.
//  - One sub-module, dmem_arb_grant: combinational winner select from valids, rr_ptr, wait_cnt
//    and state. Top holds FSM, counters, owner/response pipeline register.
// TESTING
//  1. Core only: write addr 7 data 500, then read addr 7 -> rsp_valid one cycle after each accept,
//     rdata=500.
//  2. PRIO_MODE=0, both valid 6 cycles -> grants alternate core,host,core,...; 3 responses each.
//  3. PRIO_MODE=1, STARVE_LIMIT=8, core and host both always valid -> host granted once every
//     9th cycle.
//  4. m1_lock=1, host valid 10 cycles, core valid -> host wins 4, core 1 (RELEASE), then host
//     regains burst.
//  5. rst asserted the cycle after a core read accept -> no m0_rsp_valid; outputs 0 immediately
//     (async).
//  6. Host write addr 2 in cycle N, core read addr 2 in N+1 -> core rdata = host data
//     (write-then-read order kept).

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared owner tags, priority modes and FSM states for the dmem arbiter
package dmem_arbiter_pkg;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam int PRIO_RR   = 0;
    localparam int PRIO_CORE = 1;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_HBURST  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Counter width able to hold 0..limit; never collapses to zero bits.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// rtl/dmem_arb_grant.sv - combinational winner select between core (m0) and host (m1)
module dmem_arb_grant
    import dmem_arbiter_pkg::*;
#(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 8,
    parameter int WAIT_W       = 4
) (
    input  logic              enable,
    input  logic              m0_valid,
    input  logic              m1_valid,
    input  logic              rr_ptr,
    input  logic [WAIT_W-1:0] wait_cnt,
    input  arb_state_e        state,
    output logic              gnt_m0,
    output logic              gnt_m1,
    output logic              contested
);

    localparam logic [WAIT_W-1:0] STARVE_VAL = WAIT_W'(STARVE_LIMIT);

    logic host_tie;

    always_comb begin
        gnt_m0    = 1'b0;
        gnt_m1    = 1'b0;
        contested = enable && m0_valid && m1_valid;

        // Who takes a tie in ARB: the round-robin pointer, or the host only once starved.
        if (PRIO_MODE == PRIO_RR) begin
            host_tie = (rr_ptr == OWN_HOST);
        end else begin
            host_tie = (wait_cnt >= STARVE_VAL);
        end

        if (enable) begin
            case (state)
                ST_HBURST: begin
                    gnt_m1 = m1_valid;
                    gnt_m0 = m0_valid && !m1_valid;
                end
                ST_RELEASE: begin
                    gnt_m0 = m0_valid;
                end
                default: begin
                    if (m0_valid && m1_valid) begin
                        gnt_m1 = host_tie;
                        gnt_m0 = !host_tie;
                    end else begin
                        gnt_m0 = m0_valid;
                        gnt_m1 = m1_valid;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - pipelined core/host arbiter in front of the single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_W-1:0]     m0_req_addr,
    input  logic [DATA_W-1:0]     m0_req_wdata,
    input  logic [DATA_W/8-1:0]   m0_req_wstrb,
    output logic                  m0_rsp_valid,
    output logic [DATA_W-1:0]     m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_W-1:0]     m1_req_addr,
    input  logic [DATA_W-1:0]     m1_req_wdata,
    input  logic [DATA_W/8-1:0]   m1_req_wstrb,
    output logic                  m1_rsp_valid,
    output logic [DATA_W-1:0]     m1_rsp_rdata,
    input  logic                  m1_lock,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int WAIT_W  = cnt_width(STARVE_LIMIT);
    localparam int BURST_W = cnt_width(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_TOP  = WAIT_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0] BURST_TOP = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    arb_state_e         state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_owner_q, rsp_owner_d;
    logic               rsp_we_q, rsp_we_d;

    logic               gnt_m0, gnt_m1, contested;
    logic [BURST_W-1:0] burst_nxt;

    dmem_arb_grant #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT),
        .WAIT_W       (WAIT_W)
    ) u_grant (
        .enable    (!rst),
        .m0_valid  (m0_req_valid),
        .m1_valid  (m1_req_valid),
        .rr_ptr    (rr_ptr_q),
        .wait_cnt  (wait_cnt_q),
        .state     (state_q),
        .gnt_m0    (gnt_m0),
        .gnt_m1    (gnt_m1),
        .contested (contested)
    );

    assign m0_req_ready = gnt_m0;
    assign m1_req_ready = gnt_m1;
    assign mem_en       = gnt_m0 || gnt_m1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (gnt_m1) begin
            mem_we    = m1_req_we;
            mem_addr  = m1_req_addr;
            mem_wdata = m1_req_wdata;
            mem_wstrb = m1_req_wstrb;
        end else if (gnt_m0) begin
            mem_we    = m0_req_we;
            mem_addr  = m0_req_addr;
            mem_wdata = m0_req_wdata;
            mem_wstrb = m0_req_wstrb;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        burst_nxt   = burst_cnt_q;

        // Every contested grant hands the next tie to the loser, including burst/release cycles.
        if (contested) begin
            rr_ptr_d = gnt_m1 ? OWN_CORE : OWN_HOST;
        end

        if (gnt_m1) begin
            wait_cnt_d = '0;
        end else if (m1_req_valid && (wait_cnt_q != WAIT_TOP)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        case (state_q)
            ST_ARB: begin
                if (gnt_m1 && m1_lock) begin
                    burst_cnt_d = BURST_ONE;
                    state_d     = (BURST_ONE >= BURST_TOP) ? ST_RELEASE : ST_HBURST;
                end
            end
            ST_HBURST: begin
                if (gnt_m1 && (burst_cnt_q != BURST_TOP)) begin
                    burst_nxt = burst_cnt_q + BURST_ONE;
                end
                burst_cnt_d = burst_nxt;
                // Exit decided on the count including this cycle's grant.
                if (!m1_lock || !m1_req_valid || (burst_nxt == BURST_TOP)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                burst_cnt_d = '0;
                state_d     = ST_ARB;
            end
            default: begin
                burst_cnt_d = '0;
                state_d     = ST_ARB;
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = gnt_m0 || gnt_m1;
        rsp_owner_d = gnt_m1 ? OWN_HOST : OWN_CORE;
        rsp_we_d    = gnt_m1 ? m1_req_we : (gnt_m0 && m0_req_we);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= OWN_CORE;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWN_CORE;
            rsp_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign m0_rsp_valid = rsp_valid_q && (rsp_owner_q == OWN_CORE);
    assign m1_rsp_valid = rsp_valid_q && (rsp_owner_q == OWN_HOST);
    assign m0_rsp_rdata = (m0_rsp_valid && !rsp_we_q) ? mem_rdata : '0;
    assign m1_rsp_rdata = (m1_rsp_valid && !rsp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench: round-robin and core-priority arbiters side by side
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic m0_v, m0_we, m1_v, m1_we, lock;
    logic [9:0]  m0_a, m1_a;
    logic [31:0] m0_d, m1_d;
    logic [3:0]  m0_s, m1_s;

    logic [1:0]  r0_rdy, r1_rdy, r0_rv, r1_rv, men, mwe;
    logic [31:0] r0_rd [2];
    logic [31:0] r1_rd [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2];
    logic [9:0]  ma [2];
    logic [3:0]  ms [2];

    logic [31:0] env_mem [2][1024];
    logic [31:0] mmem [2][1024];

    int n_cmp = 0;
    int n_err = 0;

    initial forever #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .PRIO_MODE(0), .STARVE_LIMIT(8), .BURST_MAX(4)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_v), .m0_req_ready(r0_rdy[0]), .m0_req_we(m0_we), .m0_req_addr(m0_a),
        .m0_req_wdata(m0_d), .m0_req_wstrb(m0_s), .m0_rsp_valid(r0_rv[0]), .m0_rsp_rdata(r0_rd[0]),
        .m1_req_valid(m1_v), .m1_req_ready(r1_rdy[0]), .m1_req_we(m1_we), .m1_req_addr(m1_a),
        .m1_req_wdata(m1_d), .m1_req_wstrb(m1_s), .m1_rsp_valid(r1_rv[0]), .m1_rsp_rdata(r1_rd[0]),
        .m1_lock(lock),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_wstrb(ms[0]), .mem_addr(ma[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .PRIO_MODE(1), .STARVE_LIMIT(8), .BURST_MAX(4)) u_pr (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_v), .m0_req_ready(r0_rdy[1]), .m0_req_we(m0_we), .m0_req_addr(m0_a),
        .m0_req_wdata(m0_d), .m0_req_wstrb(m0_s), .m0_rsp_valid(r0_rv[1]), .m0_rsp_rdata(r0_rd[1]),
        .m1_req_valid(m1_v), .m1_req_ready(r1_rdy[1]), .m1_req_we(m1_we), .m1_req_addr(m1_a),
        .m1_req_wdata(m1_d), .m1_req_wstrb(m1_s), .m1_rsp_valid(r1_rv[1]), .m1_rsp_rdata(r1_rd[1]),
        .m1_lock(lock),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_wstrb(ms[1]), .mem_addr(ma[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    // Environment data memories, one per arbiter, one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (men[i]) begin
                if (mwe[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (ms[i][b]) env_mem[i][ma[i]][b*8 +: 8] <= mwd[i][b*8 +: 8];
                end else begin
                    mrd[i] <= env_mem[i][ma[i]];
                end
            end
        end
    end

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference model: tie winner, host wait, burst progress and a pending response per arbiter.
    int   turn [2];
    int   hwait [2];
    int   bn [2];
    bit   inb [2];
    bit   rel [2];
    bit   pv [2];
    bit   po [2];
    bit   pwe [2];
    logic [31:0] pdat [2];

    always @(negedge clk) begin : cmp
        int w;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                turn[i] = 0; hwait[i] = 0; bn[i] = 0; inb[i] = 0; rel[i] = 0; pv[i] = 0;
                check("rst_ready0", i, 32'(r0_rdy[i]), 0);
                check("rst_ready1", i, 32'(r1_rdy[i]), 0);
                check("rst_mem_en", i, 32'(men[i]), 0);
                check("rst_rsp", i, 32'({r1_rv[i], r0_rv[i]}), 0);
            end else begin
                if (rel[i])                w = m0_v ? 0 : -1;
                else if (inb[i])           w = m1_v ? 1 : (m0_v ? 0 : -1);
                else if (m0_v && m1_v)     w = (i == 0) ? turn[i] : ((hwait[i] >= 8) ? 1 : 0);
                else                       w = m0_v ? 0 : (m1_v ? 1 : -1);

                check("ready0", i, 32'(r0_rdy[i]), 32'(w == 0));
                check("ready1", i, 32'(r1_rdy[i]), 32'(w == 1));
                check("mem_en", i, 32'(men[i]), 32'(w >= 0));
                if (w >= 0) begin
                    check("mem_we",    i, 32'(mwe[i]), 32'((w == 1) ? m1_we : m0_we));
                    check("mem_addr",  i, 32'(ma[i]),  32'((w == 1) ? m1_a : m0_a));
                    check("mem_wdata", i, mwd[i],      (w == 1) ? m1_d : m0_d);
                    check("mem_wstrb", i, 32'(ms[i]),  32'((w == 1) ? m1_s : m0_s));
                end
                check("m0_rsp_valid", i, 32'(r0_rv[i]), 32'(pv[i] && !po[i]));
                check("m1_rsp_valid", i, 32'(r1_rv[i]), 32'(pv[i] && po[i]));
                check("m0_rsp_rdata", i, r0_rd[i], (pv[i] && !po[i] && !pwe[i]) ? pdat[i] : 32'd0);
                check("m1_rsp_rdata", i, r1_rd[i], (pv[i] && po[i] && !pwe[i]) ? pdat[i] : 32'd0);

                pv[i] = (w >= 0);
                po[i] = (w == 1);
                if (w >= 0) begin
                    pwe[i] = (w == 1) ? m1_we : m0_we;
                    if (pwe[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (((w == 1) ? m1_s[b] : m0_s[b]))
                                mmem[i][(w == 1) ? m1_a : m0_a][b*8 +: 8] = ((w == 1) ? m1_d[b*8 +: 8] : m0_d[b*8 +: 8]);
                    end else begin
                        pdat[i] = mmem[i][(w == 1) ? m1_a : m0_a];
                    end
                end

                if (m0_v && m1_v && w >= 0) turn[i] = 1 - w;
                if (w == 1)     hwait[i] = 0;
                else if (m1_v)  hwait[i] = (hwait[i] < 8) ? hwait[i] + 1 : 8;

                if (rel[i]) begin
                    rel[i] = 0;
                end else if (inb[i]) begin
                    if (w == 1) bn[i] = bn[i] + 1;
                    if (!lock || !m1_v || bn[i] >= 4) begin
                        inb[i] = 0;
                        rel[i] = 1;
                    end
                end else if (w == 1 && lock) begin
                    inb[i] = 1;
                    bn[i]  = 1;
                end
            end
        end
    end

    task automatic cyc(input logic v0, input logic we0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [9:0] a1, input logic [31:0] d1,
                       input logic lk);
        @(posedge clk); #1;
        m0_v = v0; m0_we = we0; m0_a = a0; m0_d = d0;
        m1_v = v1; m1_we = we1; m1_a = a1; m1_d = d1;
        lock = lk;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        m0_v = 0; m1_v = 0; lock = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [6:0] hist_rr, hist_pr;
    int c0, c1, first_host, host_cnt;

    initial begin
        rst = 1'b1;
        m0_v = 0; m0_we = 0; m0_a = '0; m0_d = '0; m0_s = 4'hf;
        m1_v = 0; m1_we = 0; m1_a = '0; m1_d = '0; m1_s = 4'hf;
        lock = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Core write then read at address 7.
        cyc(1, 1, 10'd7, 32'd500, 0, 0, 10'd0, 32'd0, 0);
        check("t1_accept_wr", 0, 32'(r0_rdy[0]), 1);
        cyc(1, 0, 10'd7, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        check("t1_wr_ack_valid", 0, 32'(r0_rv[0]), 1);
        check("t1_wr_ack_data", 0, r0_rd[0], 0);
        idle();
        check("t1_rd_valid", 0, 32'(r0_rv[0]), 1);
        check("t1_rd_data", 0, r0_rd[0], 32'd500);

        // Host write at 2 immediately followed by core read at 2.
        cyc(0, 0, 10'd0, 32'd0, 1, 1, 10'd2, 32'h0000cafe, 0);
        cyc(1, 0, 10'd2, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        check("t6_host_ack", 0, 32'(r1_rv[0]), 1);
        idle();
        check("t6_core_rdata", 0, r0_rd[0], 32'h0000cafe);
        check("t6_core_rdata", 1, r0_rd[1], 32'h0000cafe);

        // Both valid six cycles: round robin alternates, priority mode keeps core.
        do_reset();
        hist_rr = '0; hist_pr = '0; c0 = 0; c1 = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd2, 32'd0, 0);
            else       idle();
            if (k < 6) begin
                hist_rr = {hist_rr[5:0], r1_rdy[0]};
                hist_pr = {hist_pr[5:0], r1_rdy[1]};
            end
            c0 += int'(r0_rv[0]);
            c1 += int'(r1_rv[0]);
        end
        check("t2_rr_order", 0, 32'(hist_rr), 32'h15);
        check("t2_pr_order", 1, 32'(hist_pr), 32'h00);
        check("t2_core_rsps", 0, 32'(c0), 3);
        check("t2_host_rsps", 0, 32'(c1), 3);

        // Core priority with starvation guard: host wins every ninth contested cycle.
        do_reset();
        first_host = -1; host_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd2, 32'd0, 0);
            if (r1_rdy[1]) begin
                if (first_host < 0) first_host = k;
                host_cnt++;
            end
        end
        check("t3_first_host", 1, 32'(first_host), 8);
        check("t3_host_grants", 1, 32'(host_cnt), 2);

        // Host burst lock: four host grants, one released core grant, host regains burst.
        do_reset();
        hist_rr = '0;
        cyc(0, 0, 10'd0, 32'd0, 1, 0, 10'd2, 32'd0, 1);
        hist_rr = {hist_rr[5:0], r1_rdy[0]};
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd2, 32'd0, 1);
            hist_rr = {hist_rr[5:0], r1_rdy[0]};
        end
        check("t4_burst_order", 0, 32'(hist_rr), 32'h7b);

        // Reset right after a core read accept: response dropped, outputs low at once.
        do_reset();
        cyc(1, 0, 10'd7, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        check("t5_accept", 0, 32'(r0_rdy[0]), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_no_rsp_async", 0, 32'(r0_rv[0]), 0);
        check("t5_no_rsp_async", 1, 32'(r0_rv[1]), 0);
        check("t5_ready_low", 0, 32'(r0_rdy[0]), 0);
        check("t5_mem_en_low", 0, 32'(men[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m0_v = 0;
        idle();
        check("t5_no_rsp_after", 0, 32'(r0_rv[0]), 0);

        repeat (3) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
